fifo_block_accumulator: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_block_acc_ctrl.sv | 66 ++++++
 rtl/fifo_block_accumulator.sv | 71 +++++++
 tb/tb_fifo_block_accumulator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO dataflow fabric and its adjacent stages.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 8;

    // Result-slot occupancy of the block accumulator.
    typedef enum logic {
        RES_IDLE = 1'b0,
        RES_PEND = 1'b1
    } res_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/fifo_block_acc_ctrl.sv
// Control for fifo_block_accumulator: word counter, result-pending flag and FIFO handshakes.
module fifo_block_acc_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned COUNT = 4,
    parameter int unsigned CNT_W = clog2_min1(COUNT)
) (
    input  logic ck,
    input  logic reset,
    input  logic in_empty,
    input  logic out_full,
    input  logic clear,
    output logic in_read,
    output logic out_write,
    output logic busy,
    output logic load_res,
    output logic clr_acc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_cnt_next;
    res_state_t       state;
    res_state_t       state_next;
    logic             pend;
    logic             last;
    logic             stall;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state   <= RES_IDLE;
            acc_cnt <= '0;
        end else begin
            state   <= state_next;
            acc_cnt <= acc_cnt_next;
        end
    end

    always_comb begin
        pend         = (state == RES_PEND);
        out_write    = pend & ~out_full;
        last         = (acc_cnt == LAST_CNT);
        // The last word may only be taken if the result slot frees up on this edge.
        stall        = last & pend & ~out_write;
        in_read      = ~in_empty & ~stall & ~clear;
        load_res     = in_read & last;
        clr_acc      = clear | load_res;
        busy         = (acc_cnt != '0) | pend;

        acc_cnt_next = acc_cnt;
        if (clr_acc) begin
            acc_cnt_next = '0;
        end else if (in_read) begin
            acc_cnt_next = acc_cnt + CNT_W'(1);
        end

        state_next = state;
        if (load_res) begin
            state_next = RES_PEND;
        end else if (out_write) begin
            state_next = RES_IDLE;
        end
    end

endmodule

// File: rtl/fifo_block_accumulator.sv
// Sums each group of COUNT upstream words into one downstream result word.
// Define FIFO_BLOCK_ACC_SIGNED_EN for a two's-complement (sign-extended) sum.
module fifo_block_accumulator
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = FIFO_DATA_W,
    parameter int unsigned COUNT     = 4,
    parameter int unsigned OUT_WIDTH = IN_WIDTH + $clog2(COUNT)
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic                 in_empty,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_read,
    input  logic                 out_full,
    output logic                 out_write,
    output logic [OUT_WIDTH-1:0] out_data,
    input  logic                 clear,
    output logic                 busy
);

    localparam int unsigned EXT_W = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] res;
    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] sum;
    logic                 load_res;
    logic                 clr_acc;

    fifo_block_acc_ctrl #(
        .COUNT (COUNT)
    ) u_ctrl (
        .ck        (ck),
        .reset     (reset),
        .in_empty  (in_empty),
        .out_full  (out_full),
        .clear     (clear),
        .in_read   (in_read),
        .out_write (out_write),
        .busy      (busy),
        .load_res  (load_res),
        .clr_acc   (clr_acc)
    );

`ifdef FIFO_BLOCK_ACC_SIGNED_EN
    assign ext = {{EXT_W{in_data[IN_WIDTH-1]}}, in_data};
`else
    assign ext = {{EXT_W{1'b0}}, in_data};
`endif

    assign sum      = acc + ext;
    assign out_data = res;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            acc <= '0;
            res <= '0;
        end else begin
            if (clr_acc) begin
                acc <= '0;
            end else if (in_read) begin
                acc <= sum;
            end
            if (load_res) begin
                res <= sum;
            end
        end
    end

endmodule

// File: tb/tb_fifo_block_accumulator.sv
// Directed self-checking bench for fifo_block_accumulator (IN_WIDTH=8, COUNT=4).
module tb_fifo_block_accumulator;

    logic       ck;
    logic       reset;
    logic       in_empty;
    logic [7:0] in_data;
    logic       in_read;
    logic       out_full;
    logic       out_write;
    logic [9:0] out_data;
    logic       clear;
    logic       busy;

    int n_checks;
    int n_fails;
    int up_q[$];
    int results[$];
    int smp_rd;
    int smp_wr;
    int smp_wd;
    int rd_total;

    fifo_block_accumulator #(
        .IN_WIDTH  (8),
        .COUNT     (4),
        .OUT_WIDTH (10)
    ) dut (
        .ck        (ck),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .in_read   (in_read),
        .out_full  (out_full),
        .out_write (out_write),
        .out_data  (out_data),
        .clear     (clear),
        .busy      (busy)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One cycle: present upstream head, sample handshakes mid-cycle, then model both FIFOs at the edge.
    task automatic tick();
        in_empty = (up_q.size() == 0);
        in_data  = (up_q.size() != 0) ? 8'(up_q[0]) : 8'h00;
        #4;
        smp_rd = int'(in_read);
        smp_wr = int'(out_write);
        smp_wd = int'(out_data);
        @(posedge ck);
        if (smp_rd == 1 && up_q.size() != 0) begin
            void'(up_q.pop_front());
            rd_total++;
        end
        if (smp_wr == 1) results.push_back(smp_wd);
        #1;
        in_empty = (up_q.size() == 0);
        in_data  = (up_q.size() != 0) ? 8'(up_q[0]) : 8'h00;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rd_total = 0;
        reset    = 1'b1;
        in_empty = 1'b1;
        in_data  = 8'h00;
        out_full = 1'b0;
        clear    = 1'b0;

        // Reset state
        #12;
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_write", int'(out_write), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_in_read", int'(in_read), 0);
        reset = 1'b0;
        @(posedge ck);
        #1;

        // Group 1,2,3,4 -> 10, written one cycle after the 4th pop
        up_q = '{1, 2, 3, 4};
        results.delete();
        ticks(4);
        check("g1_no_early_write", results.size(), 0);
        check("g1_busy_mid", int'(busy), 1);
        tick();
        check("g1_write_latency", smp_wr, 1);
        check("g1_write_data", smp_wd, 10);
        ticks(3);
        check("g1_result_count", results.size(), 1);
        check("g1_busy_idle", int'(busy), 0);

        // Back-to-back 8 x 255, no bubbles
        up_q = '{255, 255, 255, 255, 255, 255, 255, 255};
        results.delete();
        rd_total = 0;
        ticks(8);
        check("b2b_reads_in_8_cycles", rd_total, 8);
        ticks(3);
        check("b2b_result_count", results.size(), 2);
        check("b2b_result0", (results.size() > 0) ? results[0] : -1, 1020);
        check("b2b_result1", (results.size() > 1) ? results[1] : -1, 1020);
        check("b2b_busy_idle", int'(busy), 0);

        // Downstream full: stall on the 8th word, then drain
        out_full = 1'b1;
        up_q = '{255, 255, 255, 255, 255, 255, 255, 255};
        results.delete();
        rd_total = 0;
        ticks(10);
        check("full_reads_before_stall", rd_total, 7);
        check("full_stalled_in_read", smp_rd, 0);
        check("full_no_writes", results.size(), 0);
        check("full_words_left", up_q.size(), 1);
        out_full = 1'b0;
        tick();
        check("release_push_and_pop", smp_rd + smp_wr, 2);
        ticks(3);
        check("release_result_count", results.size(), 2);
        check("release_result0", (results.size() > 0) ? results[0] : -1, 1020);
        check("release_result1", (results.size() > 1) ? results[1] : -1, 1020);
        check("release_busy_idle", int'(busy), 0);

        // Clear discards partial 5+6; no pop while clear is high
        up_q = '{5, 6};
        results.delete();
        ticks(2);
        up_q = '{1, 1, 1, 1};
        clear = 1'b1;
        tick();
        check("clear_blocks_read", smp_rd, 0);
        check("clear_keeps_words", up_q.size(), 4);
        check("clear_busy_zero", int'(busy), 0);
        clear = 1'b0;
        ticks(6);
        check("clear_result_count", results.size(), 1);
        check("clear_result", (results.size() > 0) ? results[0] : -1, 4);

        // Asynchronous reset with a pending result and 3 words accumulated
        out_full = 1'b1;
        up_q = '{2, 2, 2, 2, 3, 3, 3};
        results.delete();
        ticks(8);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_res", int'(out_data), 8);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out_data", int'(out_data), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_out_write", int'(out_write), 0);
        #1;
        reset = 1'b0;
        out_full = 1'b0;
        @(posedge ck);
        #1;
        up_q = '{2, 2, 2, 2};
        results.delete();
        ticks(7);
        check("post_reset_result_count", results.size(), 1);
        check("post_reset_result", (results.size() > 0) ? results[0] : -1, 8);

        // Extension mode: -1,-1,1,127 signed vs 255,255,1,127 unsigned
        up_q = '{8'hFF, 8'hFF, 8'h01, 8'h7F};
        results.delete();
        ticks(7);
        check("ext_result_count", results.size(), 1);
`ifdef FIFO_BLOCK_ACC_SIGNED_EN
        check("ext_result_signed", (results.size() > 0) ? results[0] : -1, 126);
`else
        check("ext_result_unsigned", (results.size() > 0) ? results[0] : -1, 638);
`endif
        check("ext_busy_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
